// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the two-master single-port RAM sequencer.
// Included by ram_arbiter and ram_arbiter_pick.
package ram_arbiter_pkg;

   // IDLE -> ADDR -> ACCESS -> RESP -> IDLE, one cycle each except IDLE
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ADDR   = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   localparam logic GNT_M0 = 1'b0;
   localparam logic GNT_M1 = 1'b1;

endpackage

// File: rtl/ram_arbiter_pick.sv
// Combinational winner select between m0 and m1.
// Fixed priority (m0 first) unless RAM_ARBITER_ROUND_ROBIN_EN is defined.
module ram_arbiter_pick
   import ram_arbiter_pkg::*;
(
   input  logic m0_req,
   input  logic m1_req,
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
   input  logic rr_ptr,
`endif
   output logic winner
);

`ifdef RAM_ARBITER_ROUND_ROBIN_EN
   // Pointer only decides collisions; a lone requester always wins
   always_comb begin
      winner = GNT_M0;
      if (m0_req && m1_req) winner = rr_ptr;
      else if (m1_req)      winner = GNT_M1;
   end
`else
   always_comb begin
      winner = GNT_M0;
      if (!m0_req && m1_req) winner = GNT_M1;
   end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Sequences a shared single-port RAM (address latch, then read/write) for two
// requesters. Define RAM_ARBITER_ROUND_ROBIN_EN for round-robin collision handling.
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int WIDTH         = 8,
   parameter int ADDRESS_WIDTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     m0_req,
   input  logic                     m0_we,
   input  logic [ADDRESS_WIDTH-1:0] m0_addr,
   input  logic [WIDTH-1:0]         m0_wdata,
   output logic                     m0_ack,
   output logic [WIDTH-1:0]         m0_rdata,
   input  logic                     m1_req,
   input  logic                     m1_we,
   input  logic [ADDRESS_WIDTH-1:0] m1_addr,
   input  logic [WIDTH-1:0]         m1_wdata,
   output logic                     m1_ack,
   output logic [WIDTH-1:0]         m1_rdata,
   output logic                     ram_enable,
   output logic                     ram_addr_enable,
   output logic                     ram_write_enable,
   output logic [WIDTH-1:0]         ram_bus_in,
   input  logic [WIDTH-1:0]         ram_bus_out,
   output logic                     busy,
   output state_t                   dbg_state
);

   state_t                   state, state_nx;
   logic                     any_req, winner, grant, we_q;
   logic [WIDTH-1:0]         wdata_q;
   logic                     sel_we;
   logic [ADDRESS_WIDTH-1:0] sel_addr;
   logic [WIDTH-1:0]         sel_wdata;
   logic                     addr_en_d, wr_en_d, rd_en_d, ack0_d, ack1_d;
   logic [WIDTH-1:0]         bus_d;

   assign any_req = m0_req | m1_req;

`ifdef RAM_ARBITER_ROUND_ROBIN_EN
   logic rr_ptr;

   ram_arbiter_pick u_pick (
      .m0_req (m0_req),
      .m1_req (m1_req),
      .rr_ptr (rr_ptr),
      .winner (winner)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                        rr_ptr <= GNT_M0;
      else if (state == IDLE && any_req) rr_ptr <= ~winner;
   end
`else
   ram_arbiter_pick u_pick (
      .m0_req (m0_req),
      .m1_req (m1_req),
      .winner (winner)
   );
`endif

   assign sel_we    = (winner == GNT_M1) ? m1_we    : m0_we;
   assign sel_addr  = (winner == GNT_M1) ? m1_addr  : m0_addr;
   assign sel_wdata = (winner == GNT_M1) ? m1_wdata : m0_wdata;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (any_req) state_nx = ADDR;
         ADDR:    state_nx = ACCESS;
         ACCESS:  state_nx = RESP;
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Output values are decoded from the next state and registered below,
   // so strobes and the bus line up exactly with the state they belong to.
   always_comb begin
      addr_en_d = 1'b0;
      wr_en_d   = 1'b0;
      rd_en_d   = 1'b0;
      ack0_d    = 1'b0;
      ack1_d    = 1'b0;
      bus_d     = '0;
      case (state_nx)
         ADDR: begin
            addr_en_d = 1'b1;
            bus_d     = WIDTH'(sel_addr);
         end
         ACCESS: begin
            if (we_q) begin
               wr_en_d = 1'b1;
               bus_d   = wdata_q;
            end else begin
               rd_en_d = 1'b1;
            end
         end
         RESP: begin
            ack0_d = (grant == GNT_M0);
            ack1_d = (grant == GNT_M1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         grant   <= GNT_M0;
         we_q    <= 1'b0;
         wdata_q <= '0;
      end else if (state == IDLE && any_req) begin
         grant   <= winner;
         we_q    <= sel_we;
         wdata_q <= sel_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ram_addr_enable  <= 1'b0;
         ram_write_enable <= 1'b0;
         ram_enable       <= 1'b0;
         ram_bus_in       <= '0;
         m0_ack           <= 1'b0;
         m1_ack           <= 1'b0;
      end else begin
         ram_addr_enable  <= addr_en_d;
         ram_write_enable <= wr_en_d;
         ram_enable       <= rd_en_d;
         ram_bus_in       <= bus_d;
         m0_ack           <= ack0_d;
         m1_ack           <= ack1_d;
      end
   end

   // Read data is sampled at the edge that ends ACCESS; writes leave it alone
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         m0_rdata <= '0;
         m1_rdata <= '0;
      end else if (state == ACCESS && !we_q) begin
         if (grant == GNT_M1) m1_rdata <= ram_bus_out;
         else                 m0_rdata <= ram_bus_out;
      end
   end

   assign busy      = (state != IDLE);
   assign dbg_state = state;

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomised scoreboard bench for ram_arbiter with a behavioural RAM and
// reference model; honours RAM_ARBITER_ROUND_ROBIN_EN when defined.
module tb_ram_arbiter;
   import ram_arbiter_pkg::*;

   logic       clk, rst;
   logic       m0_req, m0_we, m1_req, m1_we;
   logic [3:0] m0_addr, m1_addr;
   logic [7:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata;
   logic       m0_ack, m1_ack;
   logic       ram_enable, ram_addr_enable, ram_write_enable;
   logic [7:0] ram_bus_in, ram_bus_out;
   logic       busy;
   state_t     dbg_state;

   ram_arbiter #(.WIDTH(8), .ADDRESS_WIDTH(4)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_ack(m0_ack), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_ack(m1_ack), .m1_rdata(m1_rdata),
      .ram_enable(ram_enable), .ram_addr_enable(ram_addr_enable),
      .ram_write_enable(ram_write_enable), .ram_bus_in(ram_bus_in),
      .ram_bus_out(ram_bus_out), .busy(busy), .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- behavioural RAM ----------------
   logic [3:0] ram_areg;
   logic [7:0] ram_mem [16];
   always @(posedge clk) begin
      if (ram_addr_enable)  ram_areg <= ram_bus_in[3:0];
      if (ram_write_enable) ram_mem[ram_areg] <= ram_bus_in;
   end
   assign ram_bus_out = ram_enable ? ram_mem[ram_areg] : 8'h00;

   // ---------------- reference model + scoreboard ----------------
   typedef struct packed {
      logic       m;
      logic       we;
      logic [3:0] a;
      logic [7:0] d;
      logic [7:0] r0;
      logic [7:0] r1;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] ref_mem [16];
   logic [7:0] model_rdata [2];
   logic       model_rr;
   int         compares = 0;
   int         mismatches = 0;
   int         ack_cyc [2];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compares++;
      if (act !== exp) begin
         mismatches++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic model_winner(input logic r0, input logic r1);
      if (r0 && r1) begin
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
         return model_rr;
`else
         return 1'b0;
`endif
      end
      return (!r0 && r1);
   endfunction

   // Apply one transaction to the model in grant order and queue its response
   function automatic void push_txn(input logic m, input logic we, input logic [3:0] a, input logic [7:0] d);
      exp_t e;
      if (we) ref_mem[a] = d;
      else    model_rdata[m] = ref_mem[a];
      model_rr = ~m;
      e.m = m; e.we = we; e.a = a; e.d = d;
      e.r0 = model_rdata[0]; e.r1 = model_rdata[1];
      exp_q.push_back(e);
   endfunction

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (rst) begin
         check("strobe_onehot", 32'($countones({ram_enable, ram_addr_enable, ram_write_enable}) <= 1), 32'd1);
         if (ram_addr_enable || ram_write_enable || ram_enable) begin
            if (exp_q.size() == 0) check("strobe_without_txn", 32'd0, 32'd1);
            else begin
               if (ram_addr_enable)  check("addr_phase_bus", 32'(ram_bus_in), {28'd0, exp_q[0].a});
               if (ram_write_enable) begin
                  check("write_strobe_type", 32'(exp_q[0].we), 32'd1);
                  check("write_phase_bus", 32'(ram_bus_in), 32'(exp_q[0].d));
               end
               if (ram_enable) check("read_strobe_type", 32'(exp_q[0].we), 32'd0);
            end
         end
         if (m0_ack || m1_ack) begin
            check("ack_exclusive", 32'(m0_ack && m1_ack), 32'd0);
            if (exp_q.size() == 0) check("ack_without_txn", 32'd0, 32'd1);
            else begin
               exp_t e;
               e = exp_q.pop_front();
               check("ack_master", 32'(m1_ack), 32'(e.m));
               check("m0_rdata", 32'(m0_rdata), 32'(e.r0));
               check("m1_rdata", 32'(m1_rdata), 32'(e.r1));
            end
            if (m0_ack) ack_cyc[0] = cyc;
            if (m1_ack) ack_cyc[1] = cyc;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic set_inputs(input logic m, input logic req, input logic we, input logic [3:0] a, input logic [7:0] d);
      if (m) begin m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d; end
      else   begin m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d; end
   endtask

   // Holds req until ack is seen, checks edges-to-ack, drops req on the ack-sampling edge
   task automatic master_txn(input logic m, input logic we, input logic [3:0] a, input logic [7:0] d,
                             input int exp_lat, input bit scramble);
      int edges = 0;
      bit seen  = 0;
      @(posedge clk); #1;
      set_inputs(m, 1'b1, we, a, d);
      while (!seen && edges < 20) begin
         @(posedge clk);
         edges++;
         if (scramble && edges == 1) begin
            #1 set_inputs(m, 1'b1, ~we, a + 4'd1, ~d);
         end
         @(negedge clk);
         if ((m ? m1_ack : m0_ack) === 1'b1) seen = 1;
      end
      check(m ? "m1_ack_seen" : "m0_ack_seen", 32'(seen), 32'd1);
      check(m ? "m1_ack_latency" : "m0_ack_latency", 32'(edges), 32'(exp_lat));
      @(posedge clk); #1;
      set_inputs(m, 1'b0, 1'b0, 4'h0, 8'h00);
   endtask

   task automatic single(input logic m, input logic we, input logic [3:0] a, input logic [7:0] d, input bit scramble);
      push_txn(m, we, a, d);
      master_txn(m, we, a, d, 3, scramble);
   endtask

   task automatic collide(input logic we0, input logic [3:0] a0, input logic [7:0] d0,
                          input logic we1, input logic [3:0] a1, input logic [7:0] d1);
      logic w;
      w = model_winner(1'b1, 1'b1);
      if (w == 1'b0) begin push_txn(0, we0, a0, d0); push_txn(1, we1, a1, d1); end
      else           begin push_txn(1, we1, a1, d1); push_txn(0, we0, a0, d0); end
      fork
         master_txn(0, we0, a0, d0, (w == 1'b0) ? 3 : 7, 0);
         master_txn(1, we1, a1, d1, (w == 1'b1) ? 3 : 7, 0);
      join
      check("collision_ack_spacing", 32'(ack_cyc[~w] - ack_cyc[w]), 32'd4);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      bit bad;
      rst = 1'b0;
      set_inputs(0, 0, 0, 4'h0, 8'h00);
      set_inputs(1, 0, 0, 4'h0, 8'h00);
      for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
      model_rdata[0] = 8'h00; model_rdata[1] = 8'h00; model_rr = 1'b0;
      ack_cyc[0] = 0; ack_cyc[1] = 0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_strobes", {29'd0, ram_enable, ram_addr_enable, ram_write_enable}, 32'd0);
      check("reset_acks", {30'd0, m0_ack, m1_ack}, 32'd0);
      check("reset_bus", 32'(ram_bus_in), 32'd0);
      check("reset_rdata", {16'd0, m0_rdata, m1_rdata}, 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      @(posedge clk); #1 rst = 1'b1;

      // Known memory contents
      for (int i = 0; i < 16; i++)
         single(1'(i % 2), 1'b1, 4'(i), 8'($urandom_range(0, 255)), 0);

      // Write then read back; m1_rdata untouched
      single(0, 1'b1, 4'h3, 8'hA5, 0);
      single(0, 1'b0, 4'h3, 8'h00, 0);
      check("m1_rdata_still_zero", 32'(m1_rdata), 32'd0);

      // Zero-extended top address, write then read by the other master
      single(0, 1'b1, 4'hF, 8'h5A, 0);
      single(1, 1'b0, 4'hF, 8'h00, 0);

      // Repeated read collisions
      repeat (3) collide(1'b0, 4'h3, 8'h00, 1'b0, 4'hF, 8'h00);

      // m1 arrives while m0 is in flight and is served right after
      push_txn(0, 1'b0, 4'hF, 8'h00);
      push_txn(1, 1'b0, 4'h3, 8'h00);
      fork
         master_txn(0, 1'b0, 4'hF, 8'h00, 3, 0);
         begin @(posedge clk); master_txn(1, 1'b0, 4'h3, 8'h00, 6, 0); end
      join
      check("back_to_back_spacing", 32'(ack_cyc[1] - ack_cyc[0]), 32'd4);

      // Inputs changed after grant are ignored
      single(1, 1'b1, 4'h1, 8'h11, 0);
      single(1, 1'b1, 4'h2, 8'h22, 0);
      single(0, 1'b0, 4'h1, 8'h00, 1);

      // Reset during a read ACCESS
      push_txn(0, 1'b0, 4'h2, 8'h00);
      @(posedge clk); #1 set_inputs(0, 1'b1, 1'b0, 4'h2, 8'h00);
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      #1;
      check("abort_strobes", {29'd0, ram_enable, ram_addr_enable, ram_write_enable}, 32'd0);
      check("abort_acks", {30'd0, m0_ack, m1_ack}, 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      set_inputs(0, 1'b0, 1'b0, 4'h0, 8'h00);
      exp_q.delete();
      model_rdata[0] = 8'h00; model_rdata[1] = 8'h00; model_rr = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      bad = 0;
      repeat (8) begin
         @(negedge clk);
         if (m0_ack || m1_ack || busy) bad = 1;
      end
      check("no_ack_after_abort", 32'(bad), 32'd0);
      check("rdata_cleared", {16'd0, m0_rdata, m1_rdata}, 32'd0);
      single(0, 1'b0, 4'h2, 8'h00, 0);

      // Randomised mix
      for (int n = 0; n < 50; n++) begin
         int kind;
         kind = $urandom_range(0, 2);
         if (kind == 2)
            collide(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
                    1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
         else
            single(1'(kind), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                   8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      end

      repeat (4) @(posedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
